seg_num_display: RTL and testbench
==================================

Name: seg_num_display

Overview:
- Parametrised numeric display engine for the calculator's seven-segment front end.
- Takes a binary result (signed or unsigned), converts it to BCD sequentially (double-dabble), blanks leading zeros, adds a minus sign, and flags overflow.
- Drives a multiplexed N-digit common-anode display from the single system clock, with no external divided clock.
- Successor to the fixed 4-digit / 8-bit bcd + code-conversion + scan path.

Parameters:
- DIGITS, 4: number of display digits (2..8).
- BIN_W, 12: width of the input value (4..27).
- CLK_HZ, 50000000: frequency of clock.
- SCAN_HZ, 2000: digit-switch rate. Each digit is held for DIV = CLK_HZ/SCAN_HZ cycles; DIV >= 2.
- SEG_ACT_LOW, 1: when 1, a lit segment drives 0.
- DIG_ACT_LOW, 1: when 1, a selected digit drives 0.

Ports:
- clock  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- value  in  BIN_W  number to display.
- is_signed  in  1  treat value as two's complement (sampled with load).
- load  in  1  single-cycle request to convert and display value.
- dp_mask  in  DIGITS  decimal point per digit, live (not latched). Bit 0 is the rightmost digit.
- busy  out  1  conversion in progress.
- ovf  out  1  last loaded value did not fit.
- seg_d  out  8  segment outputs: [7]=dp, [6:0]=g..a.
- seg_w  out  DIGITS  digit selects. Bit 0 is the rightmost digit.

Behaviour:
- Reset (rst=0, async):
  - busy=0, ovf=0.
  - Display register set to all-blank; scan index=0; prescaler=0.
  - seg_d = all segments off (8'hFF when SEG_ACT_LOW); seg_w = all digits off.
  - Any conversion in progress is aborted; no partial result is ever shown.
- Load:
  - Accepted only when busy=0 and load=1. A load while busy=1 is ignored and not queued.
  - On acceptance: neg = is_signed & value[BIN_W-1]; mag = neg ? -value : value, held BIN_W bits wide, unsigned. The most negative value negates correctly as unsigned.
  - busy goes high on the next cycle.
- Conversion FSM, states IDLE -> CONV -> COMMIT -> IDLE:
  - CONV runs exactly BIN_W cycles. Each cycle adds 3 to every BCD nibble >= 5, then shifts left by 1.
  - COMMIT takes 1 cycle and writes the display register.
  - busy is high for BIN_W+1 cycles. New content is visible from the cycle after busy falls.
- Overflow (decided at load time):
  - Limit is 10^DIGITS-1 when neg=0, and 10^(DIGITS-1)-1 when neg=1.
  - If mag exceeds the limit: ovf=1 and every digit shows '-'.
  - Otherwise ovf=0. ovf is updated at COMMIT.
- Formatting:
  - Digits above the most significant nonzero digit are blank.
  - Value 0 shows a single '0' in digit 0.
  - If neg, '-' occupies the digit immediately left of the most significant digit.
  - A -0 cannot occur.
- Scan:
  - Prescaler counts 0..DIV-1. At DIV-1 the scan index advances, wrapping DIGITS-1 -> 0.
  - Exactly one seg_w bit is active at a time.
  - seg_d and seg_w are registered and change on the same edge.
  - dp for the current digit comes from dp_mask[index]. dp is lit even on blank digits.
  - Scanning continues unaffected while busy=1; the old content is shown until COMMIT.
- Glyph codes (g..a, active-high form): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, '-'=40, blank=00.
  - Output polarity is applied last.

Decomposition:
- Package seg_pkg:
  - glyph constants (digits, minus, blank);
  - glyph code width;
  - clog2 function;
  - constant function pow10(n) for the overflow limits.
- Sub-module bin2bcd_seq:
  - parameters BIN_W, DIGITS;
  - ports clock, rst, start, bin, done, bcd[4*DIGITS-1:0];
  - iterative double-dabble.
- Top level holds the sign/overflow logic, formatter, display register and scanner.

Test Plan:
- Setup: DIGITS=4, BIN_W=12, CLK_HZ=1000, SCAN_HZ=100 (DIV=10).
- Reset released -> seg_w=4'hF, seg_d=8'hFF until first edge. Digits then cycle 0,1,2,3,0 at 10-cycle intervals, all blank.
- load value=12'd0, unsigned -> busy high for 13 cycles. Then digit0=C0 (active-low '0'), digits1..3=FF, ovf=0.
- load value=12'd4095, unsigned -> ovf=0, digits3..0 show 4,0,9,5.
- load value=12'hF85 (-123), is_signed=1 -> digit3='-' (BF), digits2..0 show 1,2,3.
- load value=12'h800 (-2048), is_signed=1 -> ovf=1, all digits show '-'.
- Then load 12'd7 mid-conversion (while busy) -> ignored; result still -2048 overflow.
- Assert rst during CONV of 12'd99 -> outputs return to reset values immediately; after release the display is blank and busy=0.
- dp_mask=4'b0100 with value 12'd5 -> seg_d[7]=0 only while digit 2 is selected; digit 2 segments are blank.

Source files
------------

// File: rtl/seg_num_display_pkg.sv
// Shared constants and constant functions for the seven-segment numeric display.
// Glyph codes are active-high (bit6..0 = g..a); polarity is applied at the pins.
package seg_pkg;

  localparam int GLYPH_W = 7;
  typedef logic [GLYPH_W-1:0] glyph_t;

  localparam glyph_t GLYPH_MINUS = 7'h40;
  localparam glyph_t GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic glyph_t digit_glyph(input logic [3:0] d);
    glyph_t g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seg_num_display_if.sv
// Request/display bus between the calculator core (master) and the display engine (slave).
interface seg_num_display_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 12
);
  logic [BIN_W-1:0]  value;
  logic              is_signed;
  logic              load;
  logic [DIGITS-1:0] dp_mask;
  logic              busy;
  logic              ovf;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] seg_w;

  modport master (output value, is_signed, load, dp_mask,
                  input  busy, ovf, seg_d, seg_w);
  modport slave  (input  value, is_signed, load, dp_mask,
                  output busy, ovf, seg_d, seg_w);
endinterface

// File: rtl/seg_num_display_bin2bcd_seq.sv
// Iterative double-dabble: the first shift happens on the start edge, so BIN_W edges
// in total; done pulses for one cycle while bcd holds the finished result.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = clog2(BIN_W + 1);

  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj_s;
  logic [BIN_W-1:0]    sh_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                done_q;

  // Add-3 correction of every nibble that would overflow past 9 after the shift.
  always_comb begin
    adj_s = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // Shift register and step counter.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      bcd_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        bcd_q <= {{(4*DIGITS-1){1'b0}}, bin[BIN_W-1]};
        sh_q  <= {bin[BIN_W-2:0], 1'b0};
        cnt_q <= CNT_W'(BIN_W - 1);
      end else if (cnt_q != '0) begin
        {bcd_q, sh_q} <= {adj_s, sh_q} << 1;
        cnt_q  <= cnt_q - CNT_W'(1);
        done_q <= (cnt_q == CNT_W'(1));
      end
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg_num_display.sv
// Numeric display engine: sign/overflow capture, BCD formatting into a glyph register,
// and a multiplexed digit scanner running directly off the system clock.
module seg_num_display
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 12,
  parameter int CLK_HZ      = 50000000,
  parameter int SCAN_HZ     = 2000,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic               clock,
  input  logic               rst,
  seg_num_display_if.slave   bus
);

  localparam int          DIV     = CLK_HZ / SCAN_HZ;
  localparam int          PS_W    = clog2(DIV);
  localparam int          IDX_W   = clog2(DIGITS);
  localparam logic [63:0] LIM_POS = pow10(DIGITS) - 64'd1;
  localparam logic [63:0] LIM_NEG = pow10(DIGITS - 1) - 64'd1;
  localparam logic [7:0]  SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? '1 : '0;

  state_t              state_q;
  logic                busy_q, ovf_q, neg_q, ovf_pend_q;
  glyph_t              disp_q [DIGITS];
  glyph_t              fmt_s  [DIGITS];
  logic                accept_s, neg_s, ovf_s, conv_done_s;
  logic [BIN_W-1:0]    mag_s;
  logic [4*DIGITS-1:0] bcd_s;
  int                  msd_s;

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          seg_d_q, seg_d_d, seg_raw_s;
  logic [DIGITS-1:0]   seg_w_q, seg_w_d, sel_raw_s;

  assign accept_s = bus.load & ~busy_q;

  // Sign and magnitude of the incoming value; overflow is judged here, at load time.
  always_comb begin
    neg_s = bus.is_signed & bus.value[BIN_W-1];
    if (neg_s) begin
      mag_s = ~bus.value + BIN_W'(1);
      ovf_s = 64'(mag_s) > LIM_NEG;
    end else begin
      mag_s = bus.value;
      ovf_s = 64'(mag_s) > LIM_POS;
    end
  end

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_conv (
    .clock (clock),
    .rst   (rst),
    .start (accept_s),
    .bin   (mag_s),
    .done  (conv_done_s),
    .bcd   (bcd_s)
  );

  // Leading-zero blanking; the minus sign sits just left of the top nonzero digit.
  always_comb begin
    msd_s = 0;
    fmt_s = '{default: GLYPH_BLANK};
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_s[4*i +: 4] != 4'd0) begin
        msd_s = i;
      end else begin
        msd_s = msd_s;
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_pend_q) begin
        fmt_s[i] = GLYPH_MINUS;
      end else if (i <= msd_s) begin
        fmt_s[i] = digit_glyph(bcd_s[4*i +: 4]);
      end else if (neg_q && (i == msd_s + 1)) begin
        fmt_s[i] = GLYPH_MINUS;
      end else begin
        fmt_s[i] = GLYPH_BLANK;
      end
    end
  end

  // Conversion FSM; the display register only changes in COMMIT.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= GLYPH_BLANK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q    <= ST_CONV;
            busy_q     <= 1'b1;
            neg_q      <= neg_s;
            ovf_pend_q <= ovf_s;
          end
        end
        ST_CONV: begin
          if (conv_done_s) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          disp_q  <= fmt_s;
          ovf_q   <= ovf_pend_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Prescaler and digit index for the scan.
  always_comb begin
    if (presc_q == PS_W'(DIV - 1)) begin
      presc_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      presc_d = presc_q + PS_W'(1);
      idx_d   = idx_q;
    end
  end

  // Pin values for the currently selected digit, polarity applied last.
  always_comb begin
    seg_raw_s            = {bus.dp_mask[idx_q], disp_q[idx_q]};
    sel_raw_s            = '0;
    sel_raw_s[idx_q]     = 1'b1;
    if (SEG_ACT_LOW != 0) begin
      seg_d_d = ~seg_raw_s;
    end else begin
      seg_d_d = seg_raw_s;
    end
    if (DIG_ACT_LOW != 0) begin
      seg_w_d = ~sel_raw_s;
    end else begin
      seg_w_d = sel_raw_s;
    end
  end

  // Scanner registers; segment and digit pins update on the same edge.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_d_q <= SEG_OFF;
      seg_w_q <= DIG_OFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_d_q <= seg_d_d;
      seg_w_q <= seg_w_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.ovf   = ovf_q;
  assign bus.seg_d = seg_d_q;
  assign bus.seg_w = seg_w_q;

endmodule

// File: tb/tb_seg_num_display.sv
// Directed bench: DIGITS=4, BIN_W=12, DIV=10, active-low segments and digits.
module tb_seg_num_display;

  typedef struct packed {
    logic [11:0]     value;
    logic            sgn;
    logic [3:0]      dp;
    logic            ovf;
    logic [3:0][7:0] seg;
  } vec_t;

  localparam int NV = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] got [4];
  vec_t vecs [NV];

  seg_num_display_if #(.DIGITS(4), .BIN_W(12)) bus ();

  seg_num_display #(
    .DIGITS(4), .BIN_W(12), .CLK_HZ(1000), .SCAN_HZ(100),
    .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
  ) dut (
    .clock (clk),
    .rst   (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Load a value, count busy cycles, optionally poke a load while busy.
  task automatic apply(input logic [11:0] v, input logic s, input logic [3:0] dp,
                       input bit inject, input string nm);
    int n;
    @(negedge clk);
    bus.value = v; bus.is_signed = s; bus.dp_mask = dp; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (inject && n == 3) begin
        bus.value = 12'd7; bus.is_signed = 1'b0; bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
    check({nm, " busy_cycles"}, n, 32'd13);
  endtask

  // Watch a little more than one full scan and record each digit's segments.
  task automatic capture(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 4; i++) got[i] = 8'h00;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      case (~bus.seg_w)
        4'b0001: got[0] = bus.seg_d;
        4'b0010: got[1] = bus.seg_d;
        4'b0100: got[2] = bus.seg_d;
        4'b1000: got[3] = bus.seg_d;
        default: bad++;
      endcase
    end
    check({nm, " onehot_errs"}, bad, 32'd0);
  endtask

  task automatic check_digits(input string nm, input logic [3:0][7:0] exp);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s digit%0d", nm, i), {24'd0, got[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    vecs[0]  = '{12'd0,    1'b0, 4'b0000, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[1]  = '{12'd4095, 1'b0, 4'b0000, 1'b0, {8'h99, 8'hC0, 8'h90, 8'h92}};
    vecs[2]  = '{12'hF85,  1'b1, 4'b0000, 1'b0, {8'hBF, 8'hF9, 8'hA4, 8'hB0}};
    vecs[3]  = '{12'h800,  1'b1, 4'b0000, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
    vecs[4]  = '{12'hC19,  1'b1, 4'b0000, 1'b0, {8'hBF, 8'h90, 8'h90, 8'h90}};
    vecs[5]  = '{12'hC18,  1'b1, 4'b0000, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
    vecs[6]  = '{12'd1000, 1'b0, 4'b0000, 1'b0, {8'hF9, 8'hC0, 8'hC0, 8'hC0}};
    vecs[7]  = '{12'h800,  1'b0, 4'b0000, 1'b0, {8'hA4, 8'hC0, 8'h99, 8'h80}};
    vecs[8]  = '{12'd42,   1'b1, 4'b0000, 1'b0, {8'hFF, 8'hFF, 8'h99, 8'hA4}};
    vecs[9]  = '{12'hFFF,  1'b1, 4'b0000, 1'b0, {8'hFF, 8'hFF, 8'hBF, 8'hF9}};
    vecs[10] = '{12'd5,    1'b0, 4'b0100, 1'b0, {8'hFF, 8'h7F, 8'hFF, 8'h92}};

    bus.value = 12'd0; bus.is_signed = 1'b0; bus.load = 1'b0; bus.dp_mask = 4'b0000;

    repeat (3) @(negedge clk);
    check("rst seg_w", {28'd0, bus.seg_w}, 32'hF);
    check("rst seg_d", {24'd0, bus.seg_d}, 32'hFF);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst ovf", {31'd0, bus.ovf}, 32'd0);

    rst_n = 1'b1;
    @(posedge clk); #1;
    check("scan p1", {28'd0, bus.seg_w}, 32'hE);
    repeat (9) @(posedge clk); #1;
    check("scan p10", {28'd0, bus.seg_w}, 32'hE);
    @(posedge clk); #1;
    check("scan p11", {28'd0, bus.seg_w}, 32'hD);
    repeat (10) @(posedge clk); #1;
    check("scan p21", {28'd0, bus.seg_w}, 32'hB);
    repeat (10) @(posedge clk); #1;
    check("scan p31", {28'd0, bus.seg_w}, 32'h7);
    repeat (10) @(posedge clk); #1;
    check("scan p41", {28'd0, bus.seg_w}, 32'hE);
    check("scan blank", {24'd0, bus.seg_d}, 32'hFF);

    for (int k = 0; k < NV; k++) begin
      apply(vecs[k].value, vecs[k].sgn, vecs[k].dp, 1'b0, $sformatf("vec%0d", k));
      check($sformatf("vec%0d ovf", k), {31'd0, bus.ovf}, {31'd0, vecs[k].ovf});
      capture($sformatf("vec%0d", k));
      check_digits($sformatf("vec%0d", k), vecs[k].seg);
    end

    // Load of 7 while busy must be dropped; the -2048 overflow result stands.
    bus.dp_mask = 4'b0000;
    apply(12'h800, 1'b1, 4'b0000, 1'b1, "ignore");
    check("ignore ovf", {31'd0, bus.ovf}, 32'd1);
    capture("ignore");
    check_digits("ignore", {8'hBF, 8'hBF, 8'hBF, 8'hBF});
    repeat (20) @(negedge clk);
    check("ignore no_requeue busy", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of converting 99.
    @(negedge clk);
    bus.value = 12'd99; bus.is_signed = 1'b0; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst busy_before", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", {31'd0, bus.busy}, 32'd0);
    check("midrst ovf", {31'd0, bus.ovf}, 32'd0);
    check("midrst seg_d", {24'd0, bus.seg_d}, 32'hFF);
    check("midrst seg_w", {28'd0, bus.seg_w}, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst busy", {31'd0, bus.busy}, 32'd0);
    capture("postrst");
    check_digits("postrst", {8'hFF, 8'hFF, 8'hFF, 8'hFF});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
